symbol_pin_mapper: RTL and testbench

//  Streaming stage directly upstream of the transistor pin-mapping modules (BC547, 2N2905, 2N2222, 2N3053).

---
 rtl/symbol_pin_mapper_if.sv | 36 +++
 rtl/symbol_pin_mapper.sv | 187 ++++++++++++++++++
 tb/tb_symbol_pin_mapper.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/symbol_pin_mapper_if.sv
// symbol_pin_mapper_if
//   Tuple-in / port-out stream bundle for symbol_pin_mapper.
//   Input stream : in_valid, in_ready, in_dev, in_pin, in_net, in_last
//   Output stream: out_valid, out_ready, out_port, out_net, out_last
//   Error report : err_valid (one-cycle pulse), err_code
//   master = upstream/downstream environment side, slave = mapper side.
interface symbol_pin_mapper_if #(
  parameter int NET_W = 16,
  parameter int PIN_W = 3
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_dev;
  logic [PIN_W-1:0] in_pin;
  logic [NET_W-1:0] in_net;
  logic             in_last;

  logic             out_valid;
  logic             out_ready;
  logic [1:0]       out_port;
  logic [NET_W-1:0] out_net;
  logic             out_last;

  logic             err_valid;
  logic [1:0]       err_code;

  modport master (
    output in_valid, in_dev, in_pin, in_net, in_last, out_ready,
    input  in_ready, out_valid, out_port, out_net, out_last, err_valid, err_code
  );

  modport slave (
    input  in_valid, in_dev, in_pin, in_net, in_last, out_ready,
    output in_ready, out_valid, out_port, out_net, out_last, err_valid, err_code
  );
endinterface

// File: rtl/symbol_pin_mapper.sv
// symbol_pin_mapper
//   Collects one symbol instance's (pin, net) tuples in any order, validates
//   them against the device pin table, then emits the net ids in the target
//   device module's port order. Malformed instances produce an error pulse
//   instead of output.
// Ports
//   clk  : clock, rising edge
//   rst  : asynchronous reset, active-high
//   bus  : symbol_pin_mapper_if.slave (input tuples, output ports, error)
// Device table (pin count; emitted symbol-pin order)
//   0 BC547  4; 1,2,3,4    1 2N2905 3; 1,2,3
//   2 2N2222 3; 3,1,2      3 2N3053 3; 1,2,3
module symbol_pin_mapper #(
  parameter int NET_W    = 16,
  parameter int PIN_W    = 3,
  parameter int MAX_PINS = 4
) (
  input logic              clk,
  input logic              rst,
  symbol_pin_mapper_if.slave bus
);

  localparam int IDX_W = (MAX_PINS > 1) ? $clog2(MAX_PINS) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    CHECK   = 2'd2,
    EMIT    = 2'd3
  } state_t;

  localparam logic [1:0] CODE_NONE    = 2'd0;
  localparam logic [1:0] CODE_MISSING = 2'd1;
  localparam logic [1:0] CODE_DUP     = 2'd2;
  localparam logic [1:0] CODE_RANGE   = 2'd3;

  function automatic logic [2:0] pin_count(input logic [1:0] dev);
    return (dev == 2'd0) ? 3'd4 : 3'd3;
  endfunction

  // 1-based symbol pin that feeds device port k.
  function automatic logic [2:0] pin_order(input logic [1:0] dev, input logic [1:0] k);
    logic [2:0] pin;
    if (dev == 2'd2) begin
      case (k)
        2'd0:    pin = 3'd3;
        2'd1:    pin = 3'd1;
        default: pin = 3'd2;
      endcase
    end else begin
      pin = {1'b0, k} + 3'd1;
    end
    return pin;
  endfunction

  state_t           state_q, state_d;
  logic [1:0]       dev_q, dev_d;
  logic [1:0]       code_q, code_d;
  logic [1:0]       k_q, k_d;
  logic [MAX_PINS-1:0] vld_q, vld_d;
  logic [NET_W-1:0] slot_q [MAX_PINS];
  logic [NET_W-1:0] slot_d [MAX_PINS];

  logic             in_ready_c;
  logic             out_valid_c;
  logic             out_last_c;
  logic             in_fire;
  logic             out_fire;
  logic [1:0]       dev_cur;
  logic [2:0]       cnt_cur;
  logic [2:0]       cnt_q;
  logic             pin_bad;
  logic [IDX_W-1:0] wr_idx;
  logic [2:0]       rd_pin;
  logic [IDX_W-1:0] rd_idx;
  logic             any_missing;
  logic [1:0]       final_code;

  assign in_ready_c  = (state_q == IDLE) || (state_q == COLLECT);
  assign out_valid_c = (state_q == EMIT);
  assign in_fire     = bus.in_valid && in_ready_c;
  assign out_fire    = out_valid_c && bus.out_ready;

  // The first tuple of an instance is range-checked against the device it
  // carries, before dev_q has latched it.
  assign dev_cur = (state_q == IDLE) ? bus.in_dev : dev_q;
  assign cnt_cur = pin_count(dev_cur);
  assign cnt_q   = pin_count(dev_q);
  assign pin_bad = (bus.in_pin == '0) || (32'(bus.in_pin) > 32'(cnt_cur));
  assign wr_idx  = IDX_W'(bus.in_pin - PIN_W'(1));

  assign rd_pin     = pin_order(dev_q, k_q);
  assign rd_idx     = IDX_W'(rd_pin - 3'd1);
  assign out_last_c = out_valid_c && ({1'b0, k_q} == (cnt_q - 3'd1));

  always_comb begin
    any_missing = 1'b0;
    for (int unsigned i = 0; i < MAX_PINS; i++) begin
      if ((i < 32'(cnt_q)) && !vld_q[i]) begin
        any_missing = 1'b1;
      end
    end
  end

  assign final_code = ((code_q == CODE_NONE) && any_missing) ? CODE_MISSING : code_q;

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.out_port  = out_valid_c ? k_q : '0;
  assign bus.out_net   = out_valid_c ? slot_q[rd_idx] : '0;
  assign bus.out_last  = out_last_c;
  assign bus.err_valid = (state_q == CHECK) && (final_code != CODE_NONE);
  assign bus.err_code  = bus.err_valid ? final_code : '0;

  always_comb begin
    state_d = state_q;
    dev_d   = dev_q;
    code_d  = code_q;
    k_d     = k_q;
    vld_d   = vld_q;
    slot_d  = slot_q;

    case (state_q)
      IDLE, COLLECT: begin
        if (in_fire) begin
          if (state_q == IDLE) begin
            dev_d = bus.in_dev;
          end
          if (pin_bad) begin
            if (code_d == CODE_NONE) code_d = CODE_RANGE;
          end else if (vld_q[wr_idx]) begin
            if (code_d == CODE_NONE) code_d = CODE_DUP;
          end else begin
            slot_d[wr_idx] = bus.in_net;
            vld_d[wr_idx]  = 1'b1;
          end
          state_d = bus.in_last ? CHECK : COLLECT;
        end
      end
      CHECK: begin
        if (final_code != CODE_NONE) begin
          vld_d   = '0;
          code_d  = CODE_NONE;
          state_d = IDLE;
        end else begin
          k_d     = '0;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (out_fire) begin
          if (out_last_c) begin
            vld_d   = '0;
            k_d     = '0;
            state_d = IDLE;
          end else begin
            k_d = k_q + 2'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      dev_q   <= '0;
      code_q  <= CODE_NONE;
      k_q     <= '0;
      vld_q   <= '0;
      for (int unsigned i = 0; i < MAX_PINS; i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      dev_q   <= dev_d;
      code_q  <= code_d;
      k_q     <= k_d;
      vld_q   <= vld_d;
      for (int unsigned i = 0; i < MAX_PINS; i++) begin
        slot_q[i] <= slot_d[i];
      end
    end
  end

endmodule

// File: tb/tb_symbol_pin_mapper.sv
module tb_symbol_pin_mapper;

  localparam int NET_W = 16;
  localparam int PIN_W = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  symbol_pin_mapper_if #(.NET_W(NET_W), .PIN_W(PIN_W)) bus ();

  symbol_pin_mapper #(.NET_W(NET_W), .PIN_W(PIN_W), .MAX_PINS(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // Current instance stimulus and expectation
  int tv_dev;
  int tv_n;
  int tv_pin [5];
  int tv_net [5];
  int exp_code;
  int exp_cnt;
  int exp_net [4];

  // Device port order, 1-based symbol pins
  int order_tbl [4][4] = '{'{1, 2, 3, 4}, '{1, 2, 3, 0}, '{3, 1, 2, 0}, '{1, 2, 3, 0}};

  typedef struct packed {
    logic [1:0]        dev;
    logic [2:0]        n;
    logic [4:0][2:0]   pin;
    logic [4:0][15:0]  net;
    logic [1:0]        code;
    logic [3:0][15:0]  onet;
  } vec_t;

  vec_t vt [4];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: applies the collection rules to the tuple list directly.
  task automatic model();
    int cnt;
    int code;
    bit seen [8];
    int val [8];
    cnt  = (tv_dev == 0) ? 4 : 3;
    code = 0;
    for (int p = 0; p < 8; p++) begin seen[p] = 0; val[p] = 0; end
    for (int i = 0; i < tv_n; i++) begin
      int p;
      p = tv_pin[i];
      if (p == 0 || p > cnt) begin
        if (code == 0) code = 3;
      end else if (seen[p]) begin
        if (code == 0) code = 2;
      end else begin
        seen[p] = 1;
        val[p]  = tv_net[i];
      end
    end
    if (code == 0)
      for (int p = 1; p <= cnt; p++)
        if (!seen[p]) code = 1;
    exp_code = code;
    exp_cnt  = cnt;
    for (int k = 0; k < 4; k++)
      exp_net[k] = (k < cnt) ? val[order_tbl[tv_dev][k]] : 0;
  endtask

  task automatic load_vec(input int i);
    tv_dev = int'(vt[i].dev);
    tv_n   = int'(vt[i].n);
    for (int j = 0; j < 5; j++) begin
      tv_pin[j] = int'(vt[i].pin[j]);
      tv_net[j] = int'(vt[i].net[j]);
    end
    exp_code = int'(vt[i].code);
    exp_cnt  = (tv_dev == 0) ? 4 : 3;
    for (int k = 0; k < 4; k++) exp_net[k] = int'(vt[i].onet[k]);
  endtask

  // mode 0: no bubbles, out_ready high; 1: random bubbles/backpressure;
  // 2: no bubbles, out_ready low for 3 cycles while port1 is presented.
  task automatic run_inst(input int mode, input string name);
    int  ti = 0, k = 0, cyc = 0, last_cyc = -1, first_ov = -1, err_cyc = -1;
    int  err_seen = 0, err_code_s = 0, stall = 0;
    bit  done = 0;
    logic ir, ov;
    while (!done && cyc < 300) begin
      @(negedge clk);
      cyc++;
      ir = bus.in_ready;
      ov = bus.out_valid;
      if (bus.err_valid) begin
        err_seen++;
        err_code_s = int'(bus.err_code);
        err_cyc = cyc;
      end else begin
        chk({name, " err_code idle"}, bus.err_code, 0);
      end
      if (ov) begin
        if (first_ov < 0) first_ov = cyc;
        chk({name, " out_port"}, bus.out_port, k);
        chk({name, " out_net"}, bus.out_net, exp_net[k]);
        chk({name, " out_last"}, bus.out_last, (k == exp_cnt - 1) ? 1 : 0);
        chk({name, " in_ready in EMIT"}, ir, 0);
      end
      if (ti < tv_n && (mode != 1 || $urandom_range(0, 3) != 0)) begin
        bus.in_valid = 1'b1;
        bus.in_dev   = (ti == 0) ? 2'(tv_dev) : 2'($urandom_range(0, 3));
        bus.in_pin   = 3'(tv_pin[ti]);
        bus.in_net   = 16'(tv_net[ti]);
        bus.in_last  = (ti == tv_n - 1);
      end else begin
        bus.in_valid = 1'b0;
        bus.in_dev   = 2'($urandom_range(0, 3));
        bus.in_pin   = 3'($urandom_range(0, 7));
        bus.in_net   = 16'($urandom);
        bus.in_last  = 1'($urandom_range(0, 1));
      end
      if (mode == 1) begin
        bus.out_ready = ($urandom_range(0, 2) != 0);
      end else if (mode == 2 && ov && k == 1 && stall < 3) begin
        bus.out_ready = 1'b0;
        stall++;
      end else begin
        bus.out_ready = 1'b1;
      end
      if (bus.in_valid && ir) begin
        if (bus.in_last) last_cyc = cyc;
        ti++;
      end
      if (ov && bus.out_ready) begin
        if (k == exp_cnt - 1) done = 1;
        k++;
      end
      if (bus.err_valid) done = 1;
    end
    chk({name, " completed in budget"}, done, 1);
    chk({name, " err pulses"}, err_seen, (exp_code != 0) ? 1 : 0);
    chk({name, " err code"}, err_code_s, exp_code);
    chk({name, " ports emitted"}, k, (exp_code != 0) ? 0 : exp_cnt);
    if (exp_code == 0) chk({name, " output latency"}, first_ov - last_cyc, 2);
    else               chk({name, " error latency"}, err_cyc - last_cyc, 1);
    if (mode == 2) chk({name, " stall cycles"}, stall, 3);
  endtask

  initial begin
    // Table order keeps a clean instance right after the missing-pin case.
    // vt[0]: dev1 (1,5)(3,7)          -> missing pin
    vt[0].dev = 2'd1; vt[0].n = 3'd2;
    vt[0].pin = {3'd0, 3'd0, 3'd0, 3'd3, 3'd1};
    vt[0].net = {16'd0, 16'd0, 16'd0, 16'd7, 16'd5};
    vt[0].code = 2'd1; vt[0].onet = '0;
    // vt[1]: dev2 (1,10)(2,20)(3,30)  -> 30,10,20
    vt[1].dev = 2'd2; vt[1].n = 3'd3;
    vt[1].pin = {3'd0, 3'd0, 3'd3, 3'd2, 3'd1};
    vt[1].net = {16'd0, 16'd0, 16'd30, 16'd20, 16'd10};
    vt[1].code = 2'd0; vt[1].onet = {16'd0, 16'd20, 16'd10, 16'd30};
    // vt[2]: dev3 (2,9)(2,8)(4,1)(1,3)(3,4) -> duplicate wins over range
    vt[2].dev = 2'd3; vt[2].n = 3'd5;
    vt[2].pin = {3'd3, 3'd1, 3'd4, 3'd2, 3'd2};
    vt[2].net = {16'd4, 16'd3, 16'd1, 16'd8, 16'd9};
    vt[2].code = 2'd2; vt[2].onet = '0;
    // vt[3]: dev0 (4,44)(2,22)(1,11)(3,33) -> 11,22,33,44
    vt[3].dev = 2'd0; vt[3].n = 3'd4;
    vt[3].pin = {3'd0, 3'd3, 3'd1, 3'd2, 3'd4};
    vt[3].net = {16'd0, 16'd33, 16'd11, 16'd22, 16'd44};
    vt[3].code = 2'd0; vt[3].onet = {16'd44, 16'd33, 16'd22, 16'd11};

    bus.in_valid = 1'b0; bus.in_dev = '0; bus.in_pin = '0; bus.in_net = '0;
    bus.in_last = 1'b0; bus.out_ready = 1'b1;

    repeat (2) @(negedge clk);
    chk("reset in_ready", bus.in_ready, 1);
    chk("reset out_valid", bus.out_valid, 0);
    chk("reset out_port", bus.out_port, 0);
    chk("reset out_net", bus.out_net, 0);
    chk("reset out_last", bus.out_last, 0);
    chk("reset err_valid", bus.err_valid, 0);
    chk("reset err_code", bus.err_code, 0);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      load_vec(i);
      run_inst(0, $sformatf("vec%0d", i));
    end

    // Backpressure while port1 is presented
    load_vec(1);
    run_inst(2, "stall");

    // Reset during EMIT after port0 has been transferred
    begin
      int w;
      load_vec(1);
      for (int i = 0; i < tv_n; i++) begin
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_dev   = 2'(tv_dev);
        bus.in_pin   = 3'(tv_pin[i]);
        bus.in_net   = 16'(tv_net[i]);
        bus.in_last  = (i == tv_n - 1);
      end
      @(negedge clk);
      bus.in_valid  = 1'b0;
      bus.in_last   = 1'b0;
      bus.out_ready = 1'b0;
      w = 0;
      while (!bus.out_valid && w < 10) begin
        @(negedge clk);
        w++;
      end
      chk("midrst reached EMIT", bus.out_valid, 1);
      chk("midrst port0 net", bus.out_net, 30);
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk("midrst port1 presented", bus.out_port, 1);
      rst = 1'b1;
      #1;
      chk("midrst out_valid", bus.out_valid, 0);
      chk("midrst in_ready", bus.in_ready, 1);
      chk("midrst out_port", bus.out_port, 0);
      chk("midrst out_net", bus.out_net, 0);
      chk("midrst err_valid", bus.err_valid, 0);
      @(negedge clk);
      chk("midrst err_valid held", bus.err_valid, 0);
      rst = 1'b0;
      run_inst(0, "after_rst");
    end

    // Randomized instances against the reference model
    for (int r = 0; r < 60; r++) begin
      int cnt;
      tv_dev = $urandom_range(0, 3);
      cnt    = (tv_dev == 0) ? 4 : 3;
      if ($urandom_range(0, 1) == 0) begin
        tv_n = cnt;
        for (int i = 0; i < 5; i++) tv_pin[i] = i + 1;
        for (int i = cnt - 1; i > 0; i--) begin
          int j, t;
          j = $urandom_range(0, i);
          t = tv_pin[i]; tv_pin[i] = tv_pin[j]; tv_pin[j] = t;
        end
      end else begin
        tv_n = $urandom_range(1, 5);
        for (int i = 0; i < 5; i++)
          tv_pin[i] = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 7) : $urandom_range(1, cnt);
      end
      for (int i = 0; i < 5; i++) tv_net[i] = $urandom_range(0, 65535);
      model();
      run_inst(1, $sformatf("rand%0d", r));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
